ram_sync_param: RTL and testbench



---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_sync_param_if.sv | 39 +++
 rtl/ram_clear_seq.sv | 47 ++++
 rtl/ram_sync_param.sv | 113 +++++++++++
 tb/tb_ram_sync_param.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the clocked scratch RAM.
// Parity helpers are only used when RAM_PARITY_EN is defined.
package ram_pkg;

  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_e;

  localparam int PAR_MAX_W = 64;

  // Callers zero-extend to PAR_MAX_W; padding does not change parity
  function automatic logic even_par(
    input logic [PAR_MAX_W-1:0] v
  );
    return ^v;
  endfunction

endpackage

// File: rtl/ram_sync_param_if.sv
// Strobe/control bundle of the scratch RAM; parity_err only exists
// when RAM_PARITY_EN is defined.
interface ram_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              write_bar;
  logic              read_bar;
  logic              output_enable;
  logic              data_valid;
  logic              busy;
`ifdef RAM_PARITY_EN
  logic              parity_err;

  modport master (
    output address, data_in, write_bar,
    output read_bar, output_enable,
    input  data_valid, busy, parity_err
  );
  modport slave (
    input  address, data_in, write_bar,
    input  read_bar, output_enable,
    output data_valid, busy, parity_err
  );
`else
  modport master (
    output address, data_in, write_bar,
    output read_bar, output_enable,
    input  data_valid, busy
  );
  modport slave (
    input  address, data_in, write_bar,
    input  read_bar, output_enable,
    output data_valid, busy
  );
`endif
endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then parks
// in READY until the next reset.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  ram_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RAM_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RAM_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = RAM_READY;
      end
      RAM_READY: ;
      default:   state_d = RAM_CLEAR;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == RAM_CLEAR);
    clr_we_o   = (state_q == RAM_CLEAR);
    clr_addr_o = cnt_q;
  end

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised clocked scratch RAM with registered reads and a
// post-reset clear; optional per-word parity under RAM_PARITY_EN.
module ram_sync_param
  import ram_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 4,
  parameter int unsigned INIT_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  ram_sync_param_if.slave   bus,
  output wire  [DATA_W-1:0] data_out
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [DATA_W-1:0] INIT_W = DATA_W'(INIT_VAL);
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  logic wr_req, rd_req;
  assign wr_req = !busy && !bus.write_bar;
  assign rd_req = !busy && bus.write_bar && !bus.read_bar;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [MEM_W-1:0]  wword;
  logic [MEM_W-1:0]  rword;

  // The sequencer owns the write port while clearing
  always_comb begin
    we    = wr_req;
    waddr = bus.address;
    wdata = bus.data_in;
    if (busy) begin
      we    = clr_we;
      waddr = clr_addr;
      wdata = INIT_W;
    end
  end

`ifdef RAM_PARITY_EN
  assign wword = {even_par(PAR_MAX_W'(wdata)), wdata};
`else
  assign wword = wdata;
`endif

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wword;
  end

  assign rword = mem[bus.address];

  logic [DATA_W-1:0] rd_q, rd_d;
  logic              dv_q, dv_d;
  logic              perr_q, perr_d;

  always_comb begin
    rd_d   = rd_q;
    dv_d   = rd_req;
    perr_d = 1'b0;
    if (rd_req) rd_d = rword[DATA_W-1:0];
`ifdef RAM_PARITY_EN
    if (rd_req)
      perr_d = rword[DATA_W] !=
               even_par(PAR_MAX_W'(rword[DATA_W-1:0]));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      dv_q   <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      dv_q   <= dv_d;
      perr_q <= perr_d;
    end
  end

  assign bus.data_valid = dv_q;
  assign bus.busy       = busy;
`ifdef RAM_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

  assign data_out = bus.output_enable ? {DATA_W{1'bz}} : rd_q;

endmodule

// File: tb/tb_ram_sync_param.sv
// Directed plus randomized bench for ram_sync_param against an
// array-based model; parity step runs only with RAM_PARITY_EN.
module tb_ram_sync_param;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  wire  [DW-1:0] data_out;

  ram_sync_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

  ram_sync_param #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .INIT_VAL (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_rd;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.write_bar = 1'b1;
    bus_if.read_bar  = 1'b1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    bus_if.address   = a;
    bus_if.data_in   = d;
    bus_if.write_bar = 1'b0;
    tick();
    idle();
    model[a] = d;
    check("wr_dv", bus_if.data_valid, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    bus_if.address  = a;
    bus_if.read_bar = 1'b0;
    tick();
    idle();
    last_rd = model[a];
    check("rd_data", data_out, last_rd);
    check("rd_dv", bus_if.data_valid, 1);
  endtask

  // Releases rst just after an edge and checks busy spans DEPTH cycles
  task automatic release_and_clear(input logic hold_wr);
    rst = 1'b0;
    if (hold_wr) begin
      bus_if.address   = 4'd2;
      bus_if.data_in   = 8'hFF;
      bus_if.write_bar = 1'b0;
      bus_if.read_bar  = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      check("busy_clr", bus_if.busy, 1);
      check("dv_clr", bus_if.data_valid, 0);
      if (i == DEPTH - 1) idle();
      tick();
    end
    check("busy_done", bus_if.busy, 0);
    model_clear();
    last_rd = '0;
  endtask

  int            op;
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;
  logic          exp_dv;

  initial begin
    bus_if.address       = '0;
    bus_if.data_in       = '0;
    bus_if.output_enable = 1'b0;
    idle();
    rst = 1'b1;
    #1;
    check("rst_busy", bus_if.busy, 1);
    check("rst_dv", bus_if.data_valid, 0);
    check("rst_dout", data_out, 0);
`ifdef RAM_PARITY_EN
    check("rst_perr", bus_if.parity_err, 0);
`endif
    tick();
    tick();
    release_and_clear(1'b0);

    do_read(4'd0);
    do_read(4'd7);
    do_read(4'd15);
    tick();
    check("idle_dv", bus_if.data_valid, 0);

    do_write(4'd3, 8'hA5);
    do_read(4'd3);
    tick();
    check("pulse_end", bus_if.data_valid, 0);
    check("hold_dout", data_out, 8'hA5);

    bus_if.address   = 4'd5;
    bus_if.data_in   = 8'h3C;
    bus_if.write_bar = 1'b0;
    bus_if.read_bar  = 1'b0;
    tick();
    idle();
    model[5] = 8'h3C;
    check("both_dv", bus_if.data_valid, 0);
    check("both_dout", data_out, 8'hA5);
    do_read(4'd5);

    do_read(4'd3);
    tick();
    bus_if.output_enable = 1'b1;
    #1;
    n_vec++;
    assert (data_out === {DW{1'bz}}) else begin
      n_err++;
      $error("FAIL oe_z: got %h want all-z", data_out);
    end
    tick();
    check("oe_dv", bus_if.data_valid, 0);
    bus_if.output_enable = 1'b0;
    #1;
    check("oe_back", data_out, 8'hA5);
    check("oe_back_dv", bus_if.data_valid, 0);

    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 3);
      ra = AW'($urandom_range(0, DEPTH - 1));
      rd = DW'($urandom_range(0, 255));
      bus_if.address   = ra;
      bus_if.data_in   = rd;
      bus_if.write_bar = !(op == 0 || op == 2);
      bus_if.read_bar  = !(op == 1 || op == 2);
      exp_dv = (op == 1);
      if (op == 1) last_rd = model[ra];
      if (op == 0 || op == 2) model[ra] = rd;
      tick();
      idle();
      check("rnd_dv", bus_if.data_valid, exp_dv);
      check("rnd_dout", data_out, last_rd);
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus_if.busy, 1);
    check("mid_rst_dout", data_out, 0);
    tick();
    release_and_clear(1'b1);
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i));

`ifdef RAM_PARITY_EN
    do_write(4'd3, 8'h5A);
    do_write(4'd9, 8'h0F);
    dut.mem[9][0] = ~dut.mem[9][0];
    bus_if.address  = 4'd9;
    bus_if.read_bar = 1'b0;
    tick();
    idle();
    check("par_data", data_out, 8'h0E);
    check("par_dv", bus_if.data_valid, 1);
    check("par_err", bus_if.parity_err, 1);
    tick();
    check("par_err_end", bus_if.parity_err, 0);
    do_read(4'd3);
    check("par_clean", bus_if.parity_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
